// File: rtl/ctrl_unit.sv
// Instruction sequencer for the 8-bit CPU: fetches one/two-byte instructions from ROM,
// decodes the opcode and drives the ALU controls, accumulator load and RAM strobes.
module ctrl_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rom_data,
    output logic [7:0] rom_addr,
    output logic       rom_rd,
    output logic [7:0] ram_addr,
    output logic       ram_rd,
    output logic       ram_wr,
    output logic [3:0] op,
    output logic [1:0] alu_sel,
    output logic [3:0] imm,
    output logic       im_int,
    output logic       pc_in,
    output logic       acc_en,
    output logic       halted
);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_OPER  = 3'd1,
        S_EXEC  = 3'd2,
        S_IMM   = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_LDO = 4'b0001;
    localparam logic [3:0] OP_LDA = 4'b0010;
    localparam logic [3:0] OP_STO = 4'b0011;
    localparam logic [3:0] OP_PRE = 4'b0100;
    localparam logic [3:0] OP_ADD = 4'b0101;
    localparam logic [3:0] OP_LDM = 4'b0110;
    localparam logic [3:0] OP_ADN = 4'b0111;
    localparam logic [3:0] OP_INC = 4'b1000;
    localparam logic [3:0] OP_DEC = 4'b1001;
    localparam logic [3:0] OP_JMP = 4'b1010;
    localparam logic [3:0] OP_CLR = 4'b1011;
    localparam logic [3:0] OP_SUB = 4'b1100;
    localparam logic [3:0] OP_IL1 = 4'b1101;
    localparam logic [3:0] OP_IL2 = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    state_t      state_r;
    state_t      next_state_s;
    logic [7:0]  pc_r;
    logic [7:0]  ir_r;
    logic [7:0]  mar_r;
    logic        im_int_r;
    logic [3:0]  opc_s;

    function automatic logic is_two_byte(input logic [3:0] opc);
        case (opc)
            OP_LDO, OP_LDA, OP_STO, OP_PRE, OP_ADD, OP_SUB, OP_JMP: is_two_byte = 1'b1;
            default:                                                is_two_byte = 1'b0;
        endcase
    endfunction

    function automatic logic is_imm_op(input logic [3:0] opc);
        is_imm_op = (opc == OP_ADN) || (opc == OP_CLR);
    endfunction

    assign opc_s    = ir_r[7:4];
    assign ram_addr = mar_r;
    assign imm      = ir_r[3:0];
    assign im_int   = im_int_r;

    // State, program counter, instruction/operand registers and the immediate strobe flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= S_FETCH;
            pc_r     <= 8'd0;
            ir_r     <= 8'd0;
            mar_r    <= 8'd0;
            im_int_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            case (state_r)
                S_FETCH: begin
                    ir_r <= rom_data;
                    pc_r <= pc_r + 8'd1;
                end
                S_OPER: begin
                    mar_r <= rom_data;
                    pc_r  <= pc_r + 8'd1;
                end
                S_EXEC: begin
                    if (opc_s == OP_JMP) begin
                        pc_r <= mar_r;
                    end else begin
                        pc_r <= pc_r;
                    end
                end
                default: begin
                    pc_r <= pc_r;
                end
            endcase
            // Only one-byte ADN/CLR raise the strobe, so they always enter EXEC straight from FETCH.
            im_int_r <= (state_r == S_FETCH) && is_imm_op(rom_data[7:4]);
        end
    end

    // Next-state selection and combinational decode of all outputs except im_int.
    always_comb begin
        next_state_s = state_r;
        rom_addr     = pc_r;
        rom_rd       = 1'b0;
        ram_rd       = 1'b0;
        ram_wr       = 1'b0;
        op           = OP_NOP;
        alu_sel      = 2'b00;
        pc_in        = 1'b0;
        acc_en       = 1'b0;
        halted       = 1'b0;
        case (state_r)
            S_FETCH: begin
                rom_rd       = 1'b1;
                pc_in        = 1'b1;
                next_state_s = is_two_byte(rom_data[7:4]) ? S_OPER : S_EXEC;
            end
            S_OPER: begin
                rom_rd       = 1'b1;
                pc_in        = 1'b1;
                next_state_s = S_EXEC;
            end
            S_EXEC: begin
                op           = opc_s;
                next_state_s = S_FETCH;
                case (opc_s)
                    OP_LDO: begin
                        rom_addr = mar_r;
                        rom_rd   = 1'b1;
                        acc_en   = 1'b1;
                    end
                    OP_LDA, OP_ADD, OP_SUB: begin
                        ram_rd  = 1'b1;
                        alu_sel = 2'b01;
                        acc_en  = 1'b1;
                    end
                    OP_PRE: begin
                        ram_rd  = 1'b1;
                        alu_sel = 2'b01;
                    end
                    OP_STO:         ram_wr = 1'b1;
                    OP_INC, OP_DEC: acc_en = 1'b1;
                    OP_ADN: begin
                        alu_sel      = 2'b10;
                        next_state_s = S_IMM;
                    end
                    OP_CLR:         next_state_s = S_IMM;
                    OP_HLT:         next_state_s = S_HALT;
                    // Illegal opcodes are hidden from the ALU.
                    OP_IL1, OP_IL2: op = OP_NOP;
                    default: begin
                        op = opc_s;
                    end
                endcase
            end
            S_IMM: begin
                op           = opc_s;
                alu_sel      = (opc_s == OP_ADN) ? 2'b10 : 2'b00;
                acc_en       = 1'b1;
                next_state_s = S_FETCH;
            end
            S_HALT: begin
                op           = OP_HLT;
                halted       = 1'b1;
                next_state_s = S_HALT;
            end
            default: begin
                next_state_s = S_FETCH;
            end
        endcase
    end

endmodule

// File: doc/ctrl_unit.md
# ctrl_unit

Instruction sequencer for the 8-bit CPU and the driving end of the ALU interface. It fetches one- and two-byte instructions from ROM and decodes the 4-bit opcode. It then drives the ALU opcode, operand source select, immediate strobe and accumulator load enable, and issues RAM reads and writes. It sits between program ROM, data RAM, the accumulator register and the ALU.

## Interface
- No parameters. All widths are fixed at 8-bit data/address and 4-bit opcode.
- `clk`  in  1  system clock. All state changes on the rising edge.
- `rst`  in  1  asynchronous reset, active-low.
- `rom_data`  in  8  ROM read data. Asynchronous read, valid in the same cycle as `rom_addr`.
- `rom_addr`  out  8  ROM address.
- `rom_rd`  out  1  ROM read strobe.
- `ram_addr`  out  8  RAM address. Equals the latched operand `mar`.
- `ram_rd`  out  1  RAM read strobe. RAM read is asynchronous.
- `ram_wr`  out  1  RAM write strobe. RAM captures the accumulator on the rising clk edge while this is high.
- `op`  out  4  ALU opcode.
- `alu_sel`  out  2  ALU `alu_in` mux select: 00 = ROM data, 01 = RAM data, 10 = zero-extended `imm`, 11 = reserved.
- `imm`  out  4  immediate nibble, equal to `ir[3:0]`.
- `im_int`  out  1  registered strobe. The ALU latches its immediate result on the rising edge of this signal.
- `pc_in`  out  1  ALU NOP pass-through select.
- `acc_en`  out  1  accumulator load enable. The accumulator captures ALU output at the clk edge ending the cycle.
- `halted`  out  1  high after HLT executes.

## Operation
- Internal registers:
  - `pc[7:0]`, program counter.
  - `ir[7:0]`, instruction register.
  - `mar[7:0]`, operand address.
  - state register.
- Instruction byte format: `{opcode[3:0], imm[3:0]}`.
- Two-byte instructions: LDO 0001, LDA 0010, STO 0011, PRE 0100, ADD 0101, SUB 1100, JMP 1010. The second byte is the 8-bit address.
- All other opcodes are one byte.
- States:
  - FETCH:
    - Drive `rom_addr = pc`, `rom_rd = 1`, `pc_in = 1`, `op = NOP`.
    - At the edge: `ir <= rom_data`, `pc <= pc + 1`.
    - Next state is OPER if the fetched opcode is two-byte, otherwise EXEC.
  - OPER:
    - Drive `rom_addr = pc`, `rom_rd = 1`, `pc_in = 1`, `op = NOP`.
    - At the edge: `mar <= rom_data`, `pc <= pc + 1`.
    - Next state is EXEC.
  - EXEC: `op = ir[7:4]`. Per-opcode actions:
    - LDO: `rom_addr = mar`, `rom_rd = 1`, `alu_sel = 00`, `acc_en = 1`.
    - LDA, ADD, SUB: `ram_rd = 1`, `alu_sel = 01`, `acc_en = 1`.
    - PRE: `ram_rd = 1`, `alu_sel = 01`, `acc_en = 0`.
    - STO: `ram_wr = 1`, `acc_en = 0`.
    - INC, DEC: `acc_en = 1`.
    - JMP: `pc <= mar`, `acc_en = 0`.
    - NOP, LDM: no side effects, `acc_en = 0`.
    - ADN: `alu_sel = 10`, `im_int = 1`; next state is IMM.
    - CLR: `im_int = 1`; the ALU latches zero; next state is IMM.
    - HLT: next state is HALT.
    - Illegal opcodes 1101 and 1110: drive `op = NOP` (the ALU never sees them), no side effects.
    - Next state is FETCH unless stated otherwise above.
  - IMM:
    - `op` and `alu_sel` are held from EXEC; `im_int = 0`; `acc_en = 1`.
    - Next state is FETCH.
  - HALT:
    - `halted = 1`, all strobes 0, `op = HLT`.
    - Remains here until reset.
- `pc` is 8-bit and wraps 0xFF→0x00, including an operand fetch at 0xFF.
- `im_int` is a flop output, set on the edge entering EXEC. It is glitch-free and its rising edge is aligned with a stable `alu_in`.

## Timing
- Reset (async assert, any state): `pc = 0`, `ir = 0`, `mar = 0`, state FETCH.
  - All outputs take their reset values immediately: `rom_addr = 0`, `rom_rd = 1`, `ram_addr = 0`, `ram_rd = 0`, `ram_wr = 0`, `op = NOP`, `alu_sel = 00`, `imm = 0`, `im_int = 0`, `pc_in = 1`, `acc_en = 0`, `halted = 0`.
  - A reset during a STO EXEC drops `ram_wr` without waiting for a clock edge.
- Reset release: the first FETCH occurs at the first rising edge after `rst` goes high.
- Instruction latency:
  - One-byte non-immediate instructions: 2 cycles (FETCH, EXEC).
  - Two-byte instructions: 3 cycles (FETCH, OPER, EXEC).
  - ADN and CLR: 3 cycles (FETCH, EXEC, IMM).
  - HLT: 2 cycles, then HALT.
- `ram_wr`, `ram_rd`, `acc_en` and `im_int` are each high for exactly one cycle per instruction.
- No strobes are asserted in FETCH or OPER except `rom_rd`.
- Outputs other than `im_int` are decoded combinationally from state and `ir`.

## Test plan
- Reset, ROM[0] = 0x80 (INC) → cycle 1 FETCH with `pc` 0→1; cycle 2 `op = 1000`, `acc_en = 1`; cycle 3 FETCH at address 0x01.
- ROM[0] = 0x73 (ADN 3) → EXEC: `op = 0111`, `alu_sel = 10`, `imm = 3`, `im_int = 1`, `acc_en = 0`. IMM: `acc_en = 1`, `im_int = 0`. Next FETCH at 0x01.
- ROM = 0x30, 0x42 (STO 0x42) → EXEC: `ram_addr = 0x42`, `ram_wr = 1` for one cycle, `acc_en = 0`; `pc = 0x02` afterwards. Repeat with 0x52, 0x42 (ADD): `ram_rd = 1`, `alu_sel = 01`, `acc_en = 1`.
- JMP: ROM = 0xA0, 0x10 → after EXEC `pc = 0x10`, next `rom_addr = 0x10`. LDA placed at 0xFF with ROM[0x00] = 0x55 → `mar = 0x55`, `pc = 0x01` after OPER.
- ROM[0] = 0xD0 (illegal) → EXEC `op = 0000`, no strobes, 2 cycles. ROM[1] = 0xF0 (HLT) → `halted = 1`, `rom_rd = 0` for 20+ cycles; `rst` low then returns `pc = 0`, `halted = 0`.
- Assert `rst` low mid-cycle during STO EXEC → `ram_wr`, `acc_en` and `im_int` fall before the next clk edge. Release → execution restarts at 0x00.
